reg_write_arbiter: RTL

- Round-robin arbiter that shares one n-bit register (async reset, sync load, enable) among NREQ requesters.
- Each requester asks for a write in either load mode (drives ld_s / inp_ld_s) or enable mode (drives en_s / inp).
- The arbiter sequences at most one write per cycle and acknowledges each write with a one-hot grant.
- Supports locked multi-cycle ownership for burst updates.

---
 rtl/reg_write_arbiter.sv | 67 ++++++
 1 files changed

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin arbiter sequencing one write per cycle into a shared register,
// with locked multi-cycle ownership for burst updates.
module reg_write_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       lock,
    input  logic [NREQ-1:0]       ld_mode,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic                  ld_s,
    output logic                  en_s,
    output logic [WIDTH-1:0]      inp_ld_s,
    output logic [WIDTH-1:0]      inp,
    output logic                  owner_valid,
    output logic [IDW-1:0]        owner_id
);
    typedef enum logic [1:0] {IDLE, GRANT, LOCKED} state_t;
    state_t state, state_nx;
    logic [IDW-1:0] ptr, win, idx;
    logic [NREQ-1:0] elig;
    logic [WIDTH-1:0] din;
    logic hold, fire, mode;
    always_comb begin
        hold = state == LOCKED && req[owner_id] && lock[owner_id];
        elig = req & ~gnt;
        idx = '0;
        win = ptr;
        // descending scan so the closest eligible index after ptr is assigned last
        for (int k = NREQ; k >= 1; k--) begin
            idx = IDW'((int'(ptr) + k) % NREQ);
            if (elig[idx]) win = idx;
        end
        if (hold) win = owner_id;
        fire = hold || |elig;
        mode = ld_mode[win];
        din = wdata[win*WIDTH +: WIDTH];
        state_nx = !fire ? IDLE : lock[win] ? LOCKED : GRANT;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= IDW'(NREQ - 1);
            gnt         <= '0;
            ld_s        <= 1'b0;
            en_s        <= 1'b0;
            inp_ld_s    <= '0;
            inp         <= '0;
            owner_valid <= 1'b0;
            owner_id    <= '0;
        end else begin
            state       <= state_nx;
            gnt         <= fire ? NREQ'(1) << win : '0;
            ld_s        <= fire && mode;
            en_s        <= fire && !mode;
            inp_ld_s    <= fire && mode ? din : '0;
            inp         <= fire && !mode ? din : '0;
            owner_valid <= fire;
            owner_id    <= fire ? win : '0;
            if (fire) ptr <= win;
        end
    end
endmodule
